rs_alu_ooo_v2: RTL

- Next-generation ALU reservation station.
- Generalised in depth (any RS_WIDTH) and in CDB snoop channel count (NUM_CDB).
- Adds oldest-first issue, same-cycle dispatch wakeup from the CDB, a valid/ready result handshake toward the CDB arbiter, correct signed/unsigned ALU semantics, and a free-slot count.
- Sits between the Dispatcher and the CDB arbiter. Wakes up on RoB-tagged CDB broadcasts and delivers branch, jalr and integer results tagged with the RoB entry.

---
 rtl/rs_alu_ooo_v2.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rs_alu_ooo_v2.sv
// ---------------------------------------------------------------------------
// rs_alu_ooo_v2 -- ALU reservation station with oldest-first issue.
//
// Holds up to RS_SIZE dispatched ALU/branch/jalr operations. Each entry waits
// on its RoB-tagged operands by snooping NUM_CDB CDB channels, and the oldest
// ready entry is computed and presented to the CDB arbiter through a
// valid/ready output register.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (0 = freeze), flush_signal
//   new_entry_*      : dispatch request and operation fields
//   CDB_update_*     : NUM_CDB packed snoop channels (en / tag / data)
//   RS_update_en/index/data : registered result toward the CDB arbiter
//   RS_update_ready  : arbiter accepts the presented result
//   free_count, isFull, isEmpty : occupancy status (combinational)
// ---------------------------------------------------------------------------
module rs_alu_ooo_v2 #(
    parameter int RS_WIDTH  = 3,
    parameter int RS_SIZE   = 1 << RS_WIDTH,
    parameter int RoB_WIDTH = 3,
    parameter int NON_DEP   = 1 << RoB_WIDTH,
    parameter int NUM_CDB   = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          flush_signal,
    input  logic                          new_entry_en,
    input  logic [RoB_WIDTH-1:0]          new_entry_robEntry,
    input  logic [6:0]                    new_entry_opcode,
    input  logic [31:0]                   new_entry_Vj,
    input  logic [31:0]                   new_entry_Vk,
    input  logic [RoB_WIDTH:0]            new_entry_Qj,
    input  logic [RoB_WIDTH:0]            new_entry_Qk,
    input  logic [31:0]                   new_entry_imm,
    input  logic [31:0]                   new_entry_pc,
    input  logic [NUM_CDB-1:0]            CDB_update_en,
    input  logic [NUM_CDB*RoB_WIDTH-1:0]  CDB_update_index,
    input  logic [NUM_CDB*32-1:0]         CDB_update_data,
    output logic                          RS_update_en,
    input  logic                          RS_update_ready,
    output logic [RoB_WIDTH-1:0]          RS_update_index,
    output logic [31:0]                   RS_update_data,
    output logic [RS_WIDTH:0]             free_count,
    output logic                          isFull,
    output logic                          isEmpty
);

    localparam int QW = RoB_WIDTH + 1;
    localparam logic [QW-1:0]       NON_DEP_Q = QW'(NON_DEP);
    localparam logic [RS_WIDTH-1:0] AGE_MAX   = RS_WIDTH'(RS_SIZE - 1);

    typedef enum logic [6:0] {
        OP_JALR  = 7'd4,
        OP_BEQ   = 7'd5,  OP_BNE  = 7'd6,  OP_BLT  = 7'd7,
        OP_BGE   = 7'd8,  OP_BLTU = 7'd9,  OP_BGEU = 7'd10,
        OP_ADDI  = 7'd19, OP_SLTI = 7'd20, OP_SLTIU = 7'd21,
        OP_XORI  = 7'd22, OP_ORI  = 7'd23, OP_ANDI = 7'd24,
        OP_SLLI  = 7'd25, OP_SRLI = 7'd26, OP_SRAI = 7'd27,
        OP_ADD   = 7'd28, OP_SUB  = 7'd29, OP_SLL  = 7'd30,
        OP_SLT   = 7'd31, OP_SLTU = 7'd32, OP_XORR = 7'd33,
        OP_SRL   = 7'd34, OP_SRA  = 7'd35, OP_ORR  = 7'd36,
        OP_ANDR  = 7'd37
    } op_e;

    // Entry storage
    logic [RS_SIZE-1:0]   busy;
    logic [6:0]           op_r   [RS_SIZE];
    logic [31:0]          vj_r   [RS_SIZE];
    logic [31:0]          vk_r   [RS_SIZE];
    logic [QW-1:0]        qj_r   [RS_SIZE];
    logic [QW-1:0]        qk_r   [RS_SIZE];
    logic [31:0]          imm_r  [RS_SIZE];
    logic [31:0]          pc_r   [RS_SIZE];
    logic [RoB_WIDTH-1:0] rob_r  [RS_SIZE];
    logic [RS_WIDTH-1:0]  age_r  [RS_SIZE];

    // Search the CDB channels for a tag; lowest-numbered matching channel wins.
    // Returns {tag, value} after the snoop.
    function automatic logic [QW+31:0] snoop(input logic [QW-1:0] q, input logic [31:0] v);
        logic [QW-1:0] q_o;
        logic [31:0]   v_o;
        logic          hit;
        q_o = q;
        v_o = v;
        hit = 1'b0;
        for (int unsigned c = 0; c < NUM_CDB; c++) begin
            if (!hit && CDB_update_en[c] &&
                q == {1'b0, CDB_update_index[c*RoB_WIDTH +: RoB_WIDTH]}) begin
                hit = 1'b1;
                q_o = NON_DEP_Q;
                v_o = CDB_update_data[c*32 +: 32];
            end
        end
        return {q_o, v_o};
    endfunction

    // Occupancy and lowest idle slot
    logic                has_free;
    logic [RS_WIDTH-1:0] free_idx;
    logic [RS_WIDTH:0]   free_cnt;

    always_comb begin
        free_cnt = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!busy[i]) begin
                free_cnt = free_cnt + (RS_WIDTH+1)'(1);
                if (!has_free) begin
                    has_free = 1'b1;
                    free_idx = RS_WIDTH'(i);
                end
            end
        end
    end

    assign free_count = free_cnt;
    assign isFull     = (free_cnt == '0);
    assign isEmpty    = (free_cnt == (RS_WIDTH+1)'(RS_SIZE));

    // Oldest ready entry; strict '>' keeps the lowest index on equal ages
    logic                found;
    logic [RS_WIDTH-1:0] sel_idx;
    logic [RS_WIDTH-1:0] best_age;

    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        best_age = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (busy[i] && qj_r[i] == NON_DEP_Q && qk_r[i] == NON_DEP_Q &&
                (!found || age_r[i] > best_age)) begin
                found    = 1'b1;
                sel_idx  = RS_WIDTH'(i);
                best_age = age_r[i];
            end
        end
    end

    logic slot_free, issue, dispatch;
    assign slot_free = !RS_update_en || RS_update_ready;
    assign issue     = slot_free && found;
    assign dispatch  = new_entry_en && has_free;

    // Dispatch bypass and per-entry wakeup values
    logic [QW-1:0] byp_qj, byp_qk;
    logic [31:0]   byp_vj, byp_vk;
    logic [QW-1:0] wk_qj [RS_SIZE];
    logic [QW-1:0] wk_qk [RS_SIZE];
    logic [31:0]   wk_vj [RS_SIZE];
    logic [31:0]   wk_vk [RS_SIZE];

    always_comb begin
        {byp_qj, byp_vj} = snoop(new_entry_Qj, new_entry_Vj);
        {byp_qk, byp_vk} = snoop(new_entry_Qk, new_entry_Vk);
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            {wk_qj[i], wk_vj[i]} = snoop(qj_r[i], vj_r[i]);
            {wk_qk[i], wk_vk[i]} = snoop(qk_r[i], vk_r[i]);
        end
    end

    // Ages are kept as "number of younger busy entries": on issue, every
    // entry older than the issued one steps down, so ages stay dense and
    // unique and the saturating increment never merges two entries.
    logic [RS_WIDTH-1:0] age_nxt [RS_SIZE];

    always_comb begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            age_nxt[i] = age_r[i];
            if (issue && age_r[i] > best_age)
                age_nxt[i] = age_nxt[i] - RS_WIDTH'(1);
            if (dispatch && age_nxt[i] != AGE_MAX)
                age_nxt[i] = age_nxt[i] + RS_WIDTH'(1);
        end
    end

    // ALU on the selected entry
    logic [6:0]  s_op;
    logic [31:0] s_vj, s_vk, s_imm, s_pc;
    logic        br_take;
    logic [31:0] alu;

    assign s_op  = op_r[sel_idx];
    assign s_vj  = vj_r[sel_idx];
    assign s_vk  = vk_r[sel_idx];
    assign s_imm = imm_r[sel_idx];
    assign s_pc  = pc_r[sel_idx];

    always_comb begin
        br_take = 1'b0;
        case (s_op)
            OP_BEQ:  br_take = (s_vj == s_vk);
            OP_BNE:  br_take = (s_vj != s_vk);
            OP_BLT:  br_take = ($signed(s_vj) <  $signed(s_vk));
            OP_BGE:  br_take = ($signed(s_vj) >= $signed(s_vk));
            OP_BLTU: br_take = (s_vj <  s_vk);
            OP_BGEU: br_take = (s_vj >= s_vk);
            default: br_take = 1'b0;
        endcase
    end

    always_comb begin
        alu = '0;
        case (s_op)
            OP_JALR:  alu = (s_vj + s_imm) & ~32'd1;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
                      alu = br_take ? (s_pc + s_imm) : (s_pc + 32'd4);
            OP_ADDI:  alu = s_vj + s_imm;
            OP_SLTI:  alu = {31'd0, $signed(s_vj) < $signed(s_imm)};
            OP_SLTIU: alu = {31'd0, s_vj < s_imm};
            OP_XORI:  alu = s_vj ^ s_imm;
            OP_ORI:   alu = s_vj | s_imm;
            OP_ANDI:  alu = s_vj & s_imm;
            OP_SLLI:  alu = s_vj << s_imm[4:0];
            OP_SRLI:  alu = s_vj >> s_imm[4:0];
            OP_SRAI:  alu = $signed(s_vj) >>> s_imm[4:0];
            OP_ADD:   alu = s_vj + s_vk;
            OP_SUB:   alu = s_vj - s_vk;
            OP_SLL:   alu = s_vj << s_vk[4:0];
            OP_SLT:   alu = {31'd0, $signed(s_vj) < $signed(s_vk)};
            OP_SLTU:  alu = {31'd0, s_vj < s_vk};
            OP_XORR:  alu = s_vj ^ s_vk;
            OP_SRL:   alu = s_vj >> s_vk[4:0];
            OP_SRA:   alu = $signed(s_vj) >>> s_vk[4:0];
            OP_ORR:   alu = s_vj | s_vk;
            OP_ANDR:  alu = s_vj & s_vk;
            default:  alu = '0;
        endcase
    end

    // State update
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy            <= '0;
            RS_update_en    <= 1'b0;
            RS_update_index <= '0;
            RS_update_data  <= '0;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                qj_r[i]  <= NON_DEP_Q;
                qk_r[i]  <= NON_DEP_Q;
                age_r[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush_signal) begin
                busy         <= '0;
                RS_update_en <= 1'b0;
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    qj_r[i]  <= NON_DEP_Q;
                    qk_r[i]  <= NON_DEP_Q;
                    age_r[i] <= '0;
                end
            end else begin
                // Idle entries hold NON_DEP tags, so wakeup never disturbs them
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    qj_r[i]  <= wk_qj[i];
                    vj_r[i]  <= wk_vj[i];
                    qk_r[i]  <= wk_qk[i];
                    vk_r[i]  <= wk_vk[i];
                    age_r[i] <= age_nxt[i];
                end

                if (issue) begin
                    busy[sel_idx]   <= 1'b0;
                    RS_update_en    <= 1'b1;
                    RS_update_index <= rob_r[sel_idx];
                    RS_update_data  <= alu;
                end else if (RS_update_ready) begin
                    RS_update_en    <= 1'b0;
                end

                // free_idx comes from pre-edge state, so it never aliases sel_idx
                if (dispatch) begin
                    busy[free_idx]   <= 1'b1;
                    op_r[free_idx]   <= new_entry_opcode;
                    rob_r[free_idx]  <= new_entry_robEntry;
                    imm_r[free_idx]  <= new_entry_imm;
                    pc_r[free_idx]   <= new_entry_pc;
                    qj_r[free_idx]   <= byp_qj;
                    vj_r[free_idx]   <= byp_vj;
                    qk_r[free_idx]   <= byp_qk;
                    vk_r[free_idx]   <= byp_vk;
                    age_r[free_idx]  <= '0;
                end
            end
        end
    end

endmodule
